// File: rtl/messbauer_saw_tooth_decoder_if.sv
// Sawtooth code bus between the velocity DAC tap and the decoder.
// The decoder returns its sweep markers, channel number and fault flags on the same bus.
interface messbauer_saw_tooth_decoder_if #(
   parameter int unsigned DATA_WIDTH = 12
);
   logic [DATA_WIDTH-1:0] in_value;
   logic                  clear_error;
   logic                  start;
   logic                  channel_strobe;
   logic [DATA_WIDTH-1:0] channel;
   logic                  dir;
   logic                  locked;
   logic                  cycle_done;
   logic [15:0]           period;
   logic [1:0]            error_flags;

   modport master (
      output in_value, clear_error,
      input  start, channel_strobe, channel, dir, locked, cycle_done, period, error_flags
   );

   modport slave (
      input  in_value, clear_error,
      output start, channel_strobe, channel, dir, locked, cycle_done, period, error_flags
   );
endinterface

// File: rtl/messbauer_saw_tooth_decoder.sv
// Locks onto the Mössbauer direct/reverse velocity sweep from the sampled DAC code.
// Regenerates the sweep and channel markers, measures channel duration and flags stream faults.
module messbauer_saw_tooth_decoder #(
   parameter int unsigned DATA_WIDTH            = 12,
   parameter int unsigned DIRECT_SLOPE_DURATION = 512,
   parameter int unsigned CHANNEL_TIMEOUT       = 65535
) (
   input logic                          clk,
   input logic                          areset_n,
   messbauer_saw_tooth_decoder_if.slave bus
);
   localparam int unsigned TIMER_W = 16;
   localparam logic [DATA_WIDTH-1:0] CODE_ONE = DATA_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] CODE_END = DATA_WIDTH'(DIRECT_SLOPE_DURATION);
   localparam logic [TIMER_W-1:0]    TIMEOUT  = TIMER_W'(CHANNEL_TIMEOUT);

   typedef enum logic [1:0] {
      ST_SYNC    = 2'd0,
      ST_DIRECT  = 2'd1,
      ST_REVERSE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] in_q, in_prev;
   logic [TIMER_W-1:0]    timer_q;
   logic                  start_q, start_d;
   logic                  strobe_q, strobe_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-1:0] channel_q, channel_d;
   logic [TIMER_W-1:0]    period_q, period_d;
   logic [1:0]            err_q, err_d;
   logic                  seq_fault, tmo_fault;

   logic change, plus_one, first_step, decrease, timed_out;

   assign change     = (in_q != in_prev);
   assign plus_one   = (in_q == DATA_WIDTH'(in_prev + CODE_ONE));
   assign first_step = (in_prev == '0) && (in_q == CODE_ONE);
   assign decrease   = (in_q < in_prev);
   assign timed_out  = !change && (timer_q == TIMEOUT);

   // State register
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) state_q <= ST_SYNC;
      else           state_q <= state_d;
   end

   // Next-state and registered-output decode
   always_comb begin
      state_d   = state_q;
      start_d   = 1'b0;
      strobe_d  = 1'b0;
      done_d    = 1'b0;
      channel_d = channel_q;
      period_d  = period_q;
      seq_fault = 1'b0;
      tmo_fault = 1'b0;
      case (state_q)
         ST_SYNC: begin
            if (first_step) begin
               start_d   = 1'b1;
               strobe_d  = 1'b1;
               channel_d = CODE_ONE;
               state_d   = ST_DIRECT;
            end
         end
         ST_DIRECT: begin
            if (change) begin
               if (plus_one) begin
                  strobe_d  = 1'b1;
                  channel_d = in_q;
                  // the 0->1 step has no preceding channel to measure
                  if (in_prev != '0) period_d = TIMER_W'(timer_q + TIMER_W'(1));
                  if (in_q == CODE_END) begin
                     done_d  = 1'b1;
                     state_d = ST_REVERSE;
                  end
               end else begin
                  seq_fault = 1'b1;
                  state_d   = ST_SYNC;
               end
            end else if (timed_out) begin
               tmo_fault = 1'b1;
               state_d   = ST_SYNC;
            end
         end
         ST_REVERSE: begin
            if (change) begin
               if (first_step) begin
                  start_d   = 1'b1;
                  strobe_d  = 1'b1;
                  channel_d = CODE_ONE;
                  state_d   = ST_DIRECT;
               end else if (!decrease) begin
                  seq_fault = 1'b1;
                  state_d   = ST_SYNC;
               end
            end else if (timed_out) begin
               tmo_fault = 1'b1;
               state_d   = ST_SYNC;
            end
         end
         default: state_d = ST_SYNC;
      endcase
      // a new fault outranks a simultaneous clear
      err_d = (bus.clear_error ? 2'b00 : err_q) | {tmo_fault, seq_fault};
   end

   // Input pipe, channel timer and output registers
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         in_q      <= '0;
         in_prev   <= '0;
         timer_q   <= '0;
         start_q   <= 1'b0;
         strobe_q  <= 1'b0;
         done_q    <= 1'b0;
         channel_q <= '0;
         period_q  <= '0;
         err_q     <= 2'b00;
      end else begin
         in_q      <= bus.in_value;
         in_prev   <= in_q;
         if (change)                timer_q <= '0;
         else if (timer_q != TIMEOUT) timer_q <= TIMER_W'(timer_q + TIMER_W'(1));
         start_q   <= start_d;
         strobe_q  <= strobe_d;
         done_q    <= done_d;
         channel_q <= channel_d;
         period_q  <= period_d;
         err_q     <= err_d;
      end
   end

   assign bus.start          = start_q;
   assign bus.channel_strobe = strobe_q;
   assign bus.cycle_done     = done_q;
   assign bus.channel        = channel_q;
   assign bus.period         = period_q;
   assign bus.error_flags    = err_q;
   assign bus.dir            = (state_q == ST_REVERSE);
   assign bus.locked         = (state_q == ST_DIRECT) || (state_q == ST_REVERSE);
endmodule
